// File: rtl/ita_oup_writer.sv
// Output writer: sink of the accelerator output stream.
// Accepts N-element beats over valid/ready, tags each with a tiled byte address
// and writes it to memory through a req/gnt port, buffering up to two beats.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  job start pulse (Idle only), latches the config below
//   base_addr_i              byte address of element (0,0)
//   row_stride_i             byte distance between output rows
//   rows_i, tiles_i          rows per tile, number of column tiles
//   valid_i, ready_o, oup_i  input beat handshake and data
//   mem_req_o, mem_gnt_i     memory write request / grant
//   mem_we_o, mem_addr_o     write enable, byte address
//   mem_wdata_o, mem_be_o    write data, byte enables
//   busy_o                   job in progress (Busy or Drain)
//   done_o                   one-cycle job completion pulse
module ita_oup_writer #(
  parameter int unsigned N      = 16,
  parameter int unsigned WI     = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [ADDR_W-1:0]     row_stride_i,
  input  logic [CNT_W-1:0]      rows_i,
  input  logic [CNT_W-1:0]      tiles_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [N*WI-1:0]       oup_i,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [N*WI-1:0]       mem_wdata_o,
  output logic [N*WI/8-1:0]     mem_be_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned DataW = N * WI;
  localparam int unsigned BeW   = DataW / 8;
  localparam logic [ADDR_W-1:0] BeatBytes = ADDR_W'(BeW);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain, StDone} state_e;

  state_e state_q, state_d;

  // Latched job configuration
  logic [CNT_W-1:0]  rows_q, tiles_q;
  logic [ADDR_W-1:0] base_q, stride_q;

  // Position of the next beat to accept
  logic [CNT_W-1:0]  row_q, tile_q;
  logic [ADDR_W-1:0] row_addr_q;  // base + row*stride
  logic [ADDR_W-1:0] tile_off_q;  // tile*BeatBytes

  // 2-entry FIFO of {addr, data}
  logic [ADDR_W-1:0] fifo_addr_q [2];
  logic [DataW-1:0]  fifo_data_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q, cnt_d;

  logic push, pop, last_row, last_beat, start_ok;

  assign ready_o   = (state_q == StBusy) && (cnt_q != 2'd2);
  assign push      = valid_i && ready_o;
  assign mem_req_o = (cnt_q != 2'd0);
  assign pop       = mem_req_o && mem_gnt_i;

  assign last_row  = (row_q == rows_q - CNT_W'(1));
  assign last_beat = last_row && (tile_q == tiles_q - CNT_W'(1));
  assign start_ok  = (rows_i != '0) && (tiles_i != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = start_ok ? StBusy : StDone;
        end
      end
      StBusy: begin
        if (push && last_beat) begin
          state_d = StDrain;
        end
      end
      // Leave as soon as the final grant empties the buffer, so done_o
      // follows the last write by a single cycle.
      StDrain: begin
        if (cnt_d == 2'd0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rows_q     <= '0;
      tiles_q    <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      row_q      <= '0;
      tile_q     <= '0;
      row_addr_q <= '0;
      tile_off_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start_i) begin
        rows_q     <= rows_i;
        tiles_q    <= tiles_i;
        base_q     <= base_addr_i;
        stride_q   <= row_stride_i;
        row_q      <= '0;
        tile_q     <= '0;
        row_addr_q <= base_addr_i;
        tile_off_q <= '0;
      end else if (push) begin
        if (last_row) begin
          row_q      <= '0;
          tile_q     <= tile_q + CNT_W'(1);
          row_addr_q <= base_q;
          tile_off_q <= tile_off_q + BeatBytes;
        end else begin
          row_q      <= row_q + CNT_W'(1);
          row_addr_q <= row_addr_q + stride_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= row_addr_q + tile_off_q;
        fifo_data_q[wr_ptr_q] <= oup_i;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign mem_we_o    = mem_req_o;
  assign mem_addr_o  = fifo_addr_q[rd_ptr_q];
  assign mem_wdata_o = fifo_data_q[rd_ptr_q];
  assign mem_be_o    = {BeW{mem_req_o}};
  assign busy_o      = (state_q == StBusy) || (state_q == StDrain);
  assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_ita_oup_writer.sv
module tb_ita_oup_writer;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [31:0]   base_addr_i, row_stride_i;
  logic [15:0]   rows_i, tiles_i;
  logic          valid_i, ready_o;
  logic [127:0]  oup_i;
  logic          mem_req_o, mem_gnt_i, mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [127:0]  mem_wdata_o;
  logic [15:0]   mem_be_o;
  logic          busy_o, done_o;

  int unsigned errs = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [31:0]  a;
    logic [127:0] d;
  } beat_t;

  always #5 clk_i = ~clk_i;

  ita_oup_writer dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .row_stride_i(row_stride_i),
    .rows_i      (rows_i),
    .tiles_i     (tiles_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .oup_i       (oup_i),
    .mem_req_o   (mem_req_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      start_i   = 1'b0;
      valid_i   = 1'($urandom);  // valid in Idle must never be accepted
      mem_gnt_i = 1'($urandom);
      oup_i     = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check_eq("idle_ready", ready_o, 1'b0);
      check_eq("idle_req", mem_req_o, 1'b0);
      check_eq("idle_busy", busy_o, 1'b0);
      check_eq("idle_done", done_o, 1'b0);
    end
    valid_i = 1'b0;
  endtask

  // vmode: 0 valid always, 1 random
  // gmode: 0 gnt always, 1 random, 2 stalled for cycles 3..8, 3 never
  // abort: nonzero -> assert reset at that loop cycle and return
  task automatic run_job(input logic [31:0] base, input logic [31:0] stride,
                         input int rows, input int tiles, input int vmode, input int gmode,
                         input int abort, input bit misuse);
    logic [31:0] addrs[$];
    beat_t       pend[$];
    beat_t       b;
    bit          active, done_due, finished, exp_ready, push, pop;
    int          left, idx;

    for (int t = 0; t < tiles; t++) begin
      for (int r = 0; r < rows; r++) begin
        addrs.push_back(base + stride * 32'(r) + 32'(t * 16));
      end
    end

    @(negedge clk_i);
    start_i      = 1'b1;
    base_addr_i  = base;
    row_stride_i = stride;
    rows_i       = 16'(rows);
    tiles_i      = 16'(tiles);
    valid_i      = misuse;
    mem_gnt_i    = 1'($urandom);
    #1;
    check_eq("start_ready", ready_o, 1'b0);
    check_eq("start_busy", busy_o, 1'b0);
    check_eq("start_done", done_o, 1'b0);

    active   = (rows != 0) && (tiles != 0);
    done_due = !active;
    left     = rows * tiles;
    idx      = 0;
    finished = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      start_i = misuse && active && ($urandom_range(0, 3) == 0);
      if (start_i) begin
        base_addr_i  = $urandom;
        row_stride_i = $urandom;
        rows_i       = 16'($urandom_range(0, 5));
        tiles_i      = 16'($urandom_range(0, 5));
      end
      if (abort != 0 && cyc == abort) begin
        start_i   = 1'b0;
        valid_i   = 1'b0;
        mem_gnt_i = 1'b0;
        check_eq("abort_pending", 32'(pend.size()), 32'd2);
        rst_ni = 1'b0;
        #1;
        check_eq("rst_req", mem_req_o, 1'b0);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_ready", ready_o, 1'b0);
        check_eq("rst_done", done_o, 1'b0);
        #1 rst_ni = 1'b1;
        return;
      end
      valid_i = (vmode == 0) ? 1'b1 : 1'($urandom);
      oup_i   = {$urandom, $urandom, $urandom, $urandom};
      unique case (gmode)
        0:       mem_gnt_i = 1'b1;
        1:       mem_gnt_i = 1'($urandom);
        2:       mem_gnt_i = !(cyc >= 3 && cyc <= 8);
        default: mem_gnt_i = 1'b0;
      endcase
      #1;
      exp_ready = active && (left > 0) && (pend.size() < 2);
      check_eq("ready", ready_o, exp_ready);
      check_eq("req", mem_req_o, pend.size() != 0);
      if (pend.size() != 0) begin
        check_eq("addr", mem_addr_o, pend[0].a);
        check_eq("wdata", mem_wdata_o, pend[0].d);
        check_eq("we", mem_we_o, 1'b1);
        check_eq("be", mem_be_o, 16'hFFFF);
      end
      check_eq("busy", busy_o, active);
      check_eq("done", done_o, done_due);
      if (done_due) begin
        finished = 1'b1;
        break;
      end
      pop  = (pend.size() != 0) && mem_gnt_i;
      push = valid_i && exp_ready;
      if (pop) void'(pend.pop_front());
      if (push) begin
        b.a = addrs[idx];
        b.d = oup_i;
        pend.push_back(b);
        idx++;
        left--;
      end
      if (active && left == 0 && pend.size() == 0) begin
        active   = 1'b0;
        done_due = 1'b1;
      end
    end
    if (!finished) check_eq("timeout", 1'b1, 1'b0);
    start_i = 1'b0;
    valid_i = 1'b0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    base_addr_i  = '0;
    row_stride_i = '0;
    rows_i       = '0;
    tiles_i      = '0;
    valid_i      = 1'b0;
    oup_i        = '0;
    mem_gnt_i    = 1'b0;
    #12;
    check_eq("rst_ready0", ready_o, 1'b0);
    check_eq("rst_req0", mem_req_o, 1'b0);
    check_eq("rst_busy0", busy_o, 1'b0);
    check_eq("rst_done0", done_o, 1'b0);
    check_eq("rst_addr0", mem_addr_o, 32'h0);
    check_eq("rst_wdata0", mem_wdata_o, 128'h0);
    check_eq("rst_be0", mem_be_o, 16'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    idle_cycles(4);
    run_job(32'h0000_1000, 32'h40, 2, 2, 0, 0, 0, 1'b0);   // basic
    idle_cycles(2);
    run_job(32'h0000_2000, 32'h80, 3, 2, 0, 2, 0, 1'b0);   // backpressure
    idle_cycles(2);
    run_job(32'h0, 32'h10, 0, 3, 0, 0, 0, 1'b0);           // degenerate
    idle_cycles(2);
    run_job(32'hFFFF_FFF0, 32'h20, 2, 1, 0, 0, 0, 1'b0);   // address wrap
    idle_cycles(2);
    run_job(32'h0000_3000, 32'h40, 4, 2, 0, 3, 4, 1'b0);   // reset with 2 buffered
    idle_cycles(2);
    run_job(32'h0000_3000, 32'h40, 2, 2, 0, 1, 0, 1'b0);   // restart from (0,0)
    idle_cycles(2);
    run_job(32'h0000_4000, 32'h100, 3, 3, 1, 1, 0, 1'b1);  // start pulses while busy
    for (int j = 0; j < 8; j++) begin
      idle_cycles($urandom_range(1, 3));
      run_job($urandom, $urandom, $urandom_range(1, 4), $urandom_range(1, 3),
              $urandom_range(0, 1), $urandom_range(0, 2), 0, 1'($urandom));
    end
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
